// File: rtl/config_pkg.sv
// config_pkg: constants and the state type shared by the configuration loader.
//   BITS_PER_CELL - configuration bits held by one logic cell
//                   (16 LUT bits, bypass, clock polarity, shift output stage)
//   CRC8_POLY     - CRC-8 polynomial used by the optional readback check
//   config_state_e- loader FSM state encoding
package config_pkg;

    localparam int BITS_PER_CELL = 19;

    localparam logic [7:0] CRC8_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_FETCH       = 3'd1,
        ST_SHIFT_LO    = 3'd2,
        ST_SHIFT_HI    = 3'd3,
        ST_READBACK_LO = 3'd4,
        ST_READBACK_HI = 3'd5,
        ST_RELEASE     = 3'd6
    } config_state_e;

endpackage

// File: rtl/config_crc8.sv
// config_crc8: serial CRC-8 accumulator, one bit per enabled cycle.
//   i_clock   - clock, rising edge
//   i_reset_n - asynchronous active-low reset, clears the CRC
//   i_clear   - synchronous clear back to the 0x00 initial value
//   i_enable  - fold i_bit into the CRC this cycle
//   i_bit     - serial data bit
//   o_crc     - current CRC value
module config_crc8
    import config_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_bit,
    output logic [7:0] o_crc
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;
    logic       feedback;

    always_comb begin
        crc_d    = crc_q;
        feedback = crc_q[7] ^ i_bit;
        if (i_clear) begin
            crc_d = 8'h00;
        end else if (i_enable) begin
            crc_d = {crc_q[6:0], 1'b0} ^ (feedback ? CRC8_POLY : 8'h00);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            crc_q <= 8'h00;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign o_crc = crc_q;

endmodule

// File: rtl/config_loader.sv
// config_loader: streams a byte-wide bitstream into a serial configuration
// chain of NUM_CELLS logic cells, generating the chain clock itself.
//
// Optional feature: define CONFIG_LOADER_READBACK_EN to add a readback pass
// that recirculates the whole chain once and compares CRC-8 of the driven
// and returned bits; a mismatch sets o_Error.
//
// Parameters
//   NUM_CELLS - cells in the chain (chain length = NUM_CELLS*BITS_PER_CELL)
//   CLK_DIV   - i_Clock cycles per o_ConfigClock phase, 1..255
// Ports
//   i_Clock, i_ResetN          - clock, async active-low reset
//   i_Start                    - one-cycle load request (ignored while busy)
//   i_DataValid, i_Data        - bitstream byte offer
//   o_DataReady                - byte accepted when this and i_DataValid are high
//   o_ConfigClock              - chain shift clock
//   o_ConfigShiftOutput        - serial data into the first cell
//   i_ConfigShiftInput         - serial data out of the last cell (readback only)
//   o_ConfigActive             - low keeps cell flops cleared during a load
//   o_Busy, o_Done, o_Error    - status
//
// state          | meaning
// ST_IDLE        | waiting for i_Start
// ST_FETCH       | o_DataReady high, waiting for the next byte
// ST_SHIFT_LO    | chain clock low, current bit presented
// ST_SHIFT_HI    | chain clock high, bit captured by the chain
// ST_READBACK_LO | chain clock low, chain end bit fed back to the start
// ST_READBACK_HI | chain clock high during readback
// ST_RELEASE     | chain clock parked low before activating the cells
module config_loader
    import config_pkg::*;
#(
    parameter int NUM_CELLS = 4,
    parameter int CLK_DIV   = 2
) (
    input  logic       i_Clock,
    input  logic       i_ResetN,
    input  logic       i_Start,
    input  logic       i_DataValid,
    input  logic [7:0] i_Data,
    output logic       o_DataReady,
    output logic       o_ConfigClock,
    output logic       o_ConfigShiftOutput,
    input  logic       i_ConfigShiftInput,
    output logic       o_ConfigActive,
    output logic       o_Busy,
    output logic       o_Done,
    output logic       o_Error
);

    localparam int CHAIN_LEN = NUM_CELLS * BITS_PER_CELL;
    localparam int CNT_W     = $clog2(CHAIN_LEN + 1);

    localparam logic [CNT_W-1:0] CHAIN_LEN_CNT = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [7:0]       DIV_LOAD      = 8'(CLK_DIV - 1);

    config_state_e    state_q, state_d;
    logic [7:0]       div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       byte_q, byte_d;
    logic [2:0]       bits_left_q, bits_left_d;
    logic             cfg_clk_q, cfg_clk_d;
    logic             cfg_sdo_q, cfg_sdo_d;
    logic             cfg_active_q, cfg_active_d;
    logic             data_ready_q, data_ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             phase_end;

`ifdef CONFIG_LOADER_READBACK_EN
    logic             error_q, error_d;
    logic             crc_clear;
    logic             crc_drv_en;
    logic             crc_rb_en;
    logic [7:0]       crc_drv;
    logic [7:0]       crc_rb;

    // CRC of every bit driven into the chain during the load
    config_crc8 u_crc_drv (
        .i_clock   (i_Clock),
        .i_reset_n (i_ResetN),
        .i_clear   (crc_clear),
        .i_enable  (crc_drv_en),
        .i_bit     (cfg_sdo_q),
        .o_crc     (crc_drv)
    );

    // CRC of every bit recirculated out of the chain end
    config_crc8 u_crc_rb (
        .i_clock   (i_Clock),
        .i_reset_n (i_ResetN),
        .i_clear   (crc_clear),
        .i_enable  (crc_rb_en),
        .i_bit     (cfg_sdo_q),
        .o_crc     (crc_rb)
    );
`else
    logic unused_shift_in;
    assign unused_shift_in = i_ConfigShiftInput;
`endif

    assign phase_end = (div_cnt_q == 8'd0);

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        byte_d       = byte_q;
        bits_left_d  = bits_left_q;
        cfg_sdo_d    = cfg_sdo_q;
        cfg_active_d = cfg_active_q;
        done_d       = 1'b0;
`ifdef CONFIG_LOADER_READBACK_EN
        error_d      = error_q;
        crc_clear    = 1'b0;
        crc_drv_en   = 1'b0;
        crc_rb_en    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_Start) begin
                    state_d      = ST_FETCH;
                    bit_cnt_d    = '0;
                    cfg_active_d = 1'b0;
`ifdef CONFIG_LOADER_READBACK_EN
                    error_d      = 1'b0;
                    crc_clear    = 1'b1;
`endif
                end
            end

            ST_FETCH: begin
                if (data_ready_q && i_DataValid) begin
                    byte_d      = i_Data;
                    bits_left_d = 3'd7;
                    cfg_sdo_d   = i_Data[0];
                    div_cnt_d   = DIV_LOAD;
                    state_d     = ST_SHIFT_LO;
                end
            end

            ST_SHIFT_LO: begin
                if (phase_end) begin
                    // The chain captures the bit on the rise entering SHIFT_HI,
                    // so that is where the bit is counted and CRC'd.
                    state_d   = ST_SHIFT_HI;
                    div_cnt_d = DIV_LOAD;
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
`ifdef CONFIG_LOADER_READBACK_EN
                    crc_drv_en = 1'b1;
`endif
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end

            ST_SHIFT_HI: begin
                if (phase_end) begin
                    div_cnt_d = DIV_LOAD;
                    if (bit_cnt_q == CHAIN_LEN_CNT) begin
                        // Leftover high bits of the final byte are dropped here.
`ifdef CONFIG_LOADER_READBACK_EN
                        state_d   = ST_READBACK_LO;
                        bit_cnt_d = '0;
                        cfg_sdo_d = i_ConfigShiftInput;
`else
                        state_d   = ST_RELEASE;
`endif
                    end else if (bits_left_q == 3'd0) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d     = ST_SHIFT_LO;
                        byte_d      = {1'b0, byte_q[7:1]};
                        cfg_sdo_d   = byte_q[1];
                        bits_left_d = bits_left_q - 3'd1;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end

`ifdef CONFIG_LOADER_READBACK_EN
            ST_READBACK_LO: begin
                if (phase_end) begin
                    state_d   = ST_READBACK_HI;
                    div_cnt_d = DIV_LOAD;
                    bit_cnt_d = bit_cnt_q + CNT_ONE;
                    crc_rb_en = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end

            ST_READBACK_HI: begin
                if (phase_end) begin
                    div_cnt_d = DIV_LOAD;
                    if (bit_cnt_q == CHAIN_LEN_CNT) begin
                        state_d = ST_RELEASE;
                        error_d = (crc_drv != crc_rb);
                    end else begin
                        state_d   = ST_READBACK_LO;
                        cfg_sdo_d = i_ConfigShiftInput;
                    end
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end
`endif

            ST_RELEASE: begin
                if (phase_end) begin
                    state_d      = ST_IDLE;
                    cfg_active_d = 1'b1;
                    done_d       = 1'b1;
                end else begin
                    div_cnt_d = div_cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs decoded from the next state so they come straight off flops.
        cfg_clk_d    = (state_d == ST_SHIFT_HI) || (state_d == ST_READBACK_HI);
        data_ready_d = (state_d == ST_FETCH);
        busy_d       = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_Clock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            state_q      <= ST_IDLE;
            div_cnt_q    <= 8'd0;
            bit_cnt_q    <= '0;
            byte_q       <= 8'd0;
            bits_left_q  <= 3'd0;
            cfg_clk_q    <= 1'b0;
            cfg_sdo_q    <= 1'b0;
            cfg_active_q <= 1'b0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_q       <= byte_d;
            bits_left_q  <= bits_left_d;
            cfg_clk_q    <= cfg_clk_d;
            cfg_sdo_q    <= cfg_sdo_d;
            cfg_active_q <= cfg_active_d;
            data_ready_q <= data_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

`ifdef CONFIG_LOADER_READBACK_EN
    always_ff @(posedge i_Clock or negedge i_ResetN) begin
        if (!i_ResetN) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign o_Error = error_q;
`else
    assign o_Error = 1'b0;
`endif

    assign o_DataReady         = data_ready_q;
    assign o_ConfigClock       = cfg_clk_q;
    assign o_ConfigShiftOutput = cfg_sdo_q;
    assign o_ConfigActive      = cfg_active_q;
    assign o_Busy              = busy_q;
    assign o_Done              = done_q;

endmodule
